// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identities used for grant and last_grant.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DEV = 1'b1;

    // Wait counter width; covers WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU and the second bus master.
// MEM_ARB_RR_EN defined: round-robin on ties (the master not served last wins).
// MEM_ARB_RR_EN undefined: fixed priority, CPU wins every tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dev_req,
    input  logic last_grant,
    output logic winner
);

`ifdef MEM_ARB_RR_EN
    // On a tie hand the port to whichever master was not served last.
    always_comb begin
        winner = REQ_CPU;
        if (cpu_req && dev_req) begin
            winner = (last_grant == REQ_CPU) ? REQ_DEV : REQ_CPU;
        end else if (dev_req) begin
            winner = REQ_DEV;
        end
    end
`else
    // History is irrelevant under fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // The dev master only wins when the CPU is not asking.
    always_comb begin
        winner = REQ_CPU;
        if (dev_req && !cpu_req) begin
            winner = REQ_DEV;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single external memory port.
// Every access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (one-cycle ack).
// Tie policy selected by MEM_ARB_RR_EN inside mem_arb_pick (undefined: CPU priority).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             grant;
    logic             last_grant;
    logic             we_q;
    logic             winner;

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dev_req    (dev_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and strobes; acks and mem_en decode straight from the state register.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        cpu_ack    = 1'b0;
        dev_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dev_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cpu_ack    = (grant == REQ_CPU);
                dev_ack    = (grant == REQ_DEV);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winning request, count wait states, capture read data, track history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            grant      <= REQ_CPU;
            last_grant <= REQ_DEV;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dev_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dev_req) begin
                        grant <= winner;
                        cnt   <= CNT_W'(WAIT_CYCLES);
                        if (winner == REQ_DEV) begin
                            we_q      <= dev_we;
                            mem_addr  <= dev_addr;
                            mem_wdata <= dev_wdata;
                        end else begin
                            we_q      <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!we_q) begin
                        if (grant == REQ_CPU) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            dev_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    last_grant <= grant;
                end
                default: begin
                end
            endcase
        end
    end

    // The CPU pipeline waits from its request up to the ack cycle.
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter for the single external memory port. Shares the port between the CPU data path (its `WriteMem`/`ReadMem`/`ExternalAddr`/`ExternalWriteData` outputs become the `cpu_*` request side) and a second bus master (DMA/peripheral). The arbiter sequences every access through a fixed wait-state window and returns a one-cycle acknowledge. It also produces the CPU stall used to hold the pipeline until its access completes.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 16, data width.
- `WAIT_CYCLES`, 1, memory wait states per access; legal range 0..15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU access request (ReadMem | WriteMem).
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  CPU read data, valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational.
- `dev_req`, `dev_we`, `dev_addr`, `dev_wdata`  in  1/1/ADDR_W/DATA_W  second master request, same meaning.
- `dev_rdata`  out  DATA_W; `dev_ack`  out  1  same meaning for the second master.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W  registered address and write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset puts the FSM in IDLE with the wait counter at 0.
- Reset values: every output is 0, `last_grant` = DEV, and both rdata registers are 0.
- **IDLE.** Requests are sampled only here. If exactly one request is high, it wins. If both are high, the winner is chosen by the arbitration policy (see Configuration).
  - On a win, the FSM latches the winner's addr, we and wdata into the `mem_*` registers, sets `grant` to the winner, loads the counter with WAIT_CYCLES and moves to ACCESS.
- **ACCESS.**
  - `mem_en`=1, and `mem_we` equals the latched we.
  - The counter decrements each cycle. When the counter is 0, the FSM captures `mem_rdata` into the granted requester's rdata register (reads only; writes leave it unchanged) and moves to RESP.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- **RESP.**
  - `mem_en`=0. The granted requester's ack is 1 for exactly this cycle. `last_grant` takes the value of `grant`.
  - The FSM always goes to IDLE next. No arbitration takes place in RESP.
- Requester rules:
  - A requester holds req, we, addr and wdata stable until it sees its ack.
  - A requester may drop req, or present a new request, on the cycle after ack.
  - Dropping req before ack is illegal. The arbiter still completes the latched access and pulses ack.
- Bus inputs change only in IDLE, so the `mem_*` outputs are stable throughout ACCESS.
- The rdata registers hold their value until the next read completes for that requester.
- Reset asserted mid-operation: all state clears immediately. `mem_en` and both acks drop asynchronously, the access is aborted, and no ack is issued.

## Timing
- Request-to-ack latency: request seen in IDLE at cycle N, ack at cycle N+WAIT_CYCLES+2.
- Minimum request-to-request period per master: WAIT_CYCLES+3 cycles.
- `cpu_stall` is combinational from `cpu_req` and the registered `cpu_ack`. It rises in the same cycle as `cpu_req` and falls in the ack cycle.
- Worst-case CPU wait under round-robin is one full dev access plus its own access: 2·(WAIT_CYCLES+3)−1 cycles from request to ack.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On simultaneous requests, the master that is not `last_grant` wins. Out of reset, `last_grant` = DEV, so the CPU wins the first tie.
- Not defined: fixed priority, where the CPU always wins ties. `last_grant` is not implemented, and the dev master can starve.

## Structure
- Package `mem_arb_pkg` contains:
  - the state enum (IDLE, ACCESS, RESP);
  - requester ID constants `REQ_CPU`=0 and `REQ_DEV`=1;
  - the counter width, fixed at 4 bits to cover WAIT_CYCLES ≤ 15.
- Sub-module `mem_arb_pick` holds the combinational winner selection: inputs are `cpu_req`, `dev_req` and `last_grant`, and the output is the winner ID. It is the only place the `MEM_ARB_RR_EN` macro is referenced.

## Test plan
- **Single CPU read**, WAIT_CYCLES=1, addr 0x0010, mem returns 0xBEEF: `mem_en` is high for 2 cycles, `cpu_ack` arrives at N+3 with `cpu_rdata`=0xBEEF, and `cpu_stall` is high for cycles N..N+2.
- **Dev write**, addr 0x1234, data 0xA5A5, WAIT_CYCLES=0: `mem_we`=1 for exactly 1 cycle with `mem_addr`/`mem_wdata` matching, `dev_ack` at N+2, and `dev_rdata` stays 0.
- **Simultaneous requests held continuously**, RR on: grants alternate CPU, DEV, CPU, DEV. With RR off: CPU wins every time and `dev_ack` never fires while `cpu_req` is held.
- **New request during RESP**: dev asserts req while the CPU is in its RESP cycle. The dev grant starts on the following IDLE cycle, not before, so dev is granted one cycle after `cpu_ack`.
- **Async reset** asserted during the second ACCESS cycle, WAIT_CYCLES=3: `mem_en` drops in the same cycle, no ack ever pulses, and after release the FSM is in IDLE and the first tie goes to the CPU.
- **WAIT_CYCLES=15 read**: `mem_en` is high for exactly 16 cycles and ack arrives at N+17.
